// File: rtl/neural_stream_pkg.sv
// rtl/neural_stream_pkg.sv - shared state type and ratio helper for the neural stream packer
package neural_stream_pkg;

    typedef enum logic [2:0] {
        NSP_IDLE  = 3'd0,
        NSP_RUN   = 3'd1,
        NSP_FLUSH = 3'd2,
        NSP_DRAIN = 3'd3,
        NSP_EOF   = 3'd4
    } nsp_state_t;

    // Returns 0 for an illegal width pair so the top can refuse to elaborate.
    function automatic int nsp_ratio(input int in_w, input int out_w);
        if (in_w <= 0 || out_w < in_w || (out_w % in_w) != 0) begin
            return 0;
        end
        return out_w / in_w;
    endfunction

endpackage

// File: rtl/stream_sync_fifo.sv
// rtl/stream_sync_fifo.sv - registered-read synchronous FIFO with occupancy count and flush
module stream_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [WIDTH-1:0] r_rd_data;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty   = (r_count == '0);
    assign full    = (r_count == FULL_CNT);
    assign w_do_rd = rd_en && !empty && !flush;
    // A same-cycle pop frees the slot, so a write into a full FIFO still lands.
    assign w_do_wr = wr_en && (!full || w_do_rd) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr  <= r_rd_ptr + AW'(1);
                r_rd_data <= r_mem[r_rd_ptr];
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= wr_data;
        end
    end

    assign rd_data = r_rd_data;
    assign count   = r_count;

endmodule

// File: rtl/neural_stream_packer.sv
// rtl/neural_stream_packer.sv - packs narrow samples into wide words and serves them on a Xillybus read port
module neural_stream_packer
    import neural_stream_pkg::*;
#(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int DEPTH = 512
) (
    input  logic                     bus_clk,
    input  logic                     reset,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_wen,
    input  logic                     stream_stop,
    input  logic                     clear_overflow,
    input  logic                     rd_open,
    input  logic                     rd_rden,
    output logic [OUT_W-1:0]         rd_data,
    output logic                     rd_empty,
    output logic                     rd_eof,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   fill_level
);

    localparam int R  = nsp_ratio(IN_W, OUT_W);
    localparam int LW = (R > 1) ? $clog2(R) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    if (R < 1) begin : g_bad_ratio
        $error("neural_stream_packer: OUT_W must be a positive multiple of IN_W");
    end
    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("neural_stream_packer: DEPTH must be a power of 2 and at least 4");
    end

    nsp_state_t        r_state;
    logic [LW-1:0]     r_lane;
    logic [OUT_W-1:0]  r_pack;
    logic              r_overflow;

    logic [OUT_W-1:0]  w_pack_next;
    logic [OUT_W-1:0]  w_push_data;
    logic              w_push;
    logic              w_drop;
    logic              w_lane_last;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;

    always_comb begin
        w_pack_next = r_pack;
        for (int i = 0; i < R; i++) begin
            if (r_lane == LW'(i)) begin
                w_pack_next[i*IN_W +: IN_W] = in_data;
            end
        end
        w_lane_last = (r_lane == LW'(R - 1));
        w_push      = 1'b0;
        w_push_data = w_pack_next;
        if (rd_open) begin
            case (r_state)
                NSP_RUN: begin
                    w_push = in_wen && w_lane_last;
                end
                NSP_FLUSH: begin
                    // r_pack is zeroed after every push, so unfilled lanes read as zero.
                    w_push      = (r_lane != '0);
                    w_push_data = r_pack;
                end
                default: begin
                    w_push = 1'b0;
                end
            endcase
        end
    end

    // When full the FIFO is non-empty, so an accepted read always makes room.
    assign w_drop = w_push && w_full && !rd_rden;

    stream_sync_fifo #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (bus_clk),
        .rst     (reset),
        .flush   (!rd_open),
        .wr_en   (w_push),
        .wr_data (w_push_data),
        .rd_en   (rd_rden),
        .rd_data (rd_data),
        .count   (w_count),
        .full    (w_full),
        .empty   (w_empty)
    );

    always_ff @(posedge bus_clk or posedge reset) begin
        if (reset) begin
            r_state    <= NSP_IDLE;
            r_lane     <= '0;
            r_pack     <= '0;
            r_overflow <= 1'b0;
        end else if (!rd_open) begin
            r_state    <= NSP_IDLE;
            r_lane     <= '0;
            r_pack     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
            case (r_state)
                NSP_IDLE: begin
                    r_state <= NSP_RUN;
                end
                NSP_RUN: begin
                    if (in_wen) begin
                        if (w_lane_last) begin
                            r_lane <= '0;
                            r_pack <= '0;
                        end else begin
                            r_lane <= r_lane + LW'(1);
                            r_pack <= w_pack_next;
                        end
                    end
                    if (stream_stop) begin
                        r_state <= NSP_FLUSH;
                    end
                end
                NSP_FLUSH: begin
                    r_lane  <= '0;
                    r_pack  <= '0;
                    r_state <= NSP_DRAIN;
                end
                NSP_DRAIN: begin
                    if (w_count == '0) begin
                        r_state <= NSP_EOF;
                    end
                end
                NSP_EOF: begin
                    r_state <= NSP_EOF;
                end
                default: begin
                    r_state <= NSP_IDLE;
                end
            endcase
        end
    end

    assign rd_empty   = w_empty || (r_state == NSP_EOF);
    assign rd_eof     = (r_state == NSP_EOF) || ((r_state == NSP_DRAIN) && (w_count == '0));
    assign overflow   = r_overflow;
    assign fill_level = w_count;

endmodule

// File: doc/neural_stream_packer.md
# neural_stream_packer

Parametrised, single-clock packer between the SPI acquisition path and a Xillybus FPGA-to-CPU read stream. It accepts narrow sample words already in the `bus_clk` domain and packs R = OUT_W/IN_W of them into each output word. It buffers packed words in an internal FIFO and drives the Xillybus read-port handshake, including a real end-of-stream (`eof`) sequence. It adds a sticky overflow flag and a fill level. It is the generalised successor to the fixed 16→32 neural-data path.

## Interface
Parameters:
- `IN_W`, 16, input sample width.
- `OUT_W`, 32, output word width; must be an integer multiple of `IN_W` (R = OUT_W/IN_W ≥ 1). Elaboration error otherwise.
- `DEPTH`, 512, FIFO depth in output words; power of 2, ≥ 4.

Ports:
- `bus_clk` in 1: the only clock. All ports are synchronous to it.
- `reset` in 1: asynchronous, active-high reset.
- `in_data` in IN_W: sample word.
- `in_wen` in 1: sample valid. One sample is taken per cycle while high. There is no backpressure.
- `stream_stop` in 1: single-cycle pulse marking end of acquisition.
- `clear_overflow` in 1: clears `overflow`.
- `rd_open` in 1: Xillybus `user_r_*_open`.
- `rd_rden` in 1: Xillybus `user_r_*_rden`.
- `rd_data` out OUT_W: popped word.
- `rd_empty` out 1: FIFO empty.
- `rd_eof` out 1: end of stream.
- `overflow` out 1: sticky; at least one packed word was dropped.
- `fill_level` out $clog2(DEPTH)+1: current FIFO occupancy.

## Operation
- States: IDLE, RUN, FLUSH, DRAIN, EOF.
- IDLE:
  - Entered at reset, or whenever `rd_open`=0 (from any state, highest priority).
  - Effects: FIFO flushed, packer lane index cleared, partial word discarded, `overflow` cleared.
  - `in_wen` is ignored.
  - Transition: `rd_open`=1 → RUN.
- RUN:
  - Each `in_wen` writes `in_data` into lane k (bits k·IN_W +: IN_W). Lane 0 is the LSBs; first sample ends up lowest.
  - When k = R−1, the assembled word is pushed and k returns to 0.
  - If the FIFO is full at push time, the word is dropped, `overflow` is set, and FIFO contents are unchanged.
  - `stream_stop` → FLUSH. If `in_wen` is high in the same cycle, that sample is packed first.
- FLUSH (1 cycle):
  - If k≠0, the partial word is pushed with unfilled lanes zero and k cleared. Full-FIFO drop rule applies.
  - Then → DRAIN.
  - `in_wen` is ignored from FLUSH onward.
- DRAIN: when FIFO count = 0 → EOF.
- EOF:
  - `rd_eof`=1 and `rd_empty`=1.
  - Held until `rd_open`=0 → IDLE.
- Reads:
  - `rd_rden` with count>0 pops the head word; it appears on `rd_data` the next cycle.
  - `rd_rden` with count=0 is ignored: `rd_data` holds and there is no underflow.
- `overflow`:
  - Cleared by `clear_overflow`.
  - A set and a clear in the same cycle: set wins.
- Reset values: `rd_data`=0, `rd_empty`=1, `rd_eof`=0, `overflow`=0, `fill_level`=0, state IDLE, k=0.

## Timing
- A push registered at edge t is visible at t+1: `fill_level` is incremented and `rd_empty` deasserts.
- Latency from the R-th `in_wen` at edge t to data poppable is 1 cycle; `rd_rden` at t+1 gives `rd_data` at t+2.
- Push and pop in the same cycle: `fill_level` unchanged, both succeed. This includes the full case: a pop frees the slot for the same-cycle push, so there is no drop.
- `rd_empty` and `rd_eof` are decoded combinationally from registered count and state.
- `rd_eof` rises the cycle after the last pop empties the FIFO in DRAIN.
- `rd_open` falling mid-FLUSH or mid-DRAIN:
  - Next cycle is IDLE with `fill_level`=0.
  - Any `rd_rden` in that cycle is ignored.
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Count is one bit wider to distinguish full from empty.

## Structure
- Package `neural_stream_pkg`:
  - state enum `nsp_state_t`.
  - localparam function `nsp_ratio(IN_W, OUT_W)` with the divisibility check.
- Sub-module `stream_sync_fifo`:
  - Parameters WIDTH and DEPTH.
  - Registered-read FIFO with count output and a synchronous `flush` input.
- The packer register, lane counter and FSM live in the top module.

## Test plan
- Defaults, `rd_open`=1, 4 samples 0x1111, 0x2222, 0x3333, 0x4444 → two words, 0x22221111 then 0x44443333, each 1 cycle after its 2nd sample.
- 3 samples, then `stream_stop` → words 0x22221111 and 0x00003333. `rd_eof`=1 the cycle after the second pop; it drops 1 cycle after `rd_open`=0.
- DEPTH=4, no reads, 10 samples → `fill_level`=4 and `overflow`=1. Pops return the first 4 words only. `clear_overflow` → 0. Simultaneous set and clear → 1.
- FIFO full plus simultaneous push and `rd_rden` → no drop, `overflow` stays 0, `fill_level` stays 4.
- IN_W=8, OUT_W=32, samples 0x01..0x04 → 0x04030201. `rd_rden` on an empty FIFO → `rd_data` unchanged.
- `reset` asserted asynchronously mid-DRAIN → all outputs at reset values immediately, before the next clock edge. After release with `rd_open`=1, normal packing resumes from lane 0.
